shift_unit_arbiter: RTL and testbench
=====================================

# shift_unit_arbiter

Shares one 32-bit left barrel shifter (`shift_left_32bit`) between two requesters, e.g. the ALU and load/store byte-lane alignment. It arbitrates round-robin and runs a valid/ready handshake on each request port. Logical and arithmetic right shifts are built from the left shifter by bit reversal. Each accepted request returns one registered response, tagged with the requester ID.

## Interface
Parameters:
- none; datapath width fixed at 32, shift amount at 5 bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has a request.
- `req0_ready` out 1: requester 0 accepted this cycle.
- `req0_data` in 32: operand.
- `req0_amt` in 5: shift amount.
- `req0_op` in 2: operation (00 SLL, 01 SRL, 10 SRA, 11 reserved).
- `req1_valid`, `req1_ready`, `req1_data`, `req1_amt`, `req1_op`: same as requester 0, for requester 1.
- `resp_valid` out 1: response held.
- `resp_ready` in 1: consumer accepts the response.
- `resp_data` out 32: shift result.
- `resp_id` out 1: requester that issued the request.
- `resp_err` out 1: reserved op code was received.

## Operation
- FSM has two states, IDLE and RESP. Reset enters IDLE.
- The block accepts a request when `can_accept = (state==IDLE) | (state==RESP & resp_ready)`.
- Arbitration:
  - Pointer `last` records the last requester granted; reset value is 1, so req0 wins first.
  - With both valid, grant `~last`. With one valid, grant that one.
  - `reqN_ready = can_accept & grant==N`; this is combinational and at most one is high.
- Datapath, one instance of `shift_left_32bit`:
  - Amount is zero-extended to 32 bits on `shift_sel`.
  - SLL: shifter(data, amt).
  - SRL: rev(shifter(rev(data), amt)), where rev is a 32-bit bit reversal.
  - SRA: the SRL result OR'd with fill; fill = `~rev(shifter(32'hFFFF_FFFF reversed, amt))` when `data[31]=1`, else 0. The fill computation needs a second shifter instance, counted in the RTL budget.
  - Reserved op 11: `resp_data = data`, `resp_err = 1`.
- On accept:
  - Register `resp_data`, `resp_id`, `resp_err`.
  - Set `resp_valid`, update `last`, go to RESP.
- In RESP:
  - Response outputs hold stable until `resp_ready`.
  - `resp_ready` with no accept: clear `resp_valid`, go to IDLE.
  - `resp_ready` with an accept in the same cycle: load the new response and stay in RESP, giving back-to-back throughput.
- Requesters may drop `valid` before `ready`; there is no ordering obligation. Request fields are only sampled on accept.
- Reset mid-transaction:
  - The response is discarded and `resp_valid` goes to 0 on the next edge.
  - A request accepted in the reset cycle is not accepted: all `ready` outputs are 0 while `rst=1`.

## Timing
- Reset values: `resp_valid=0`, `resp_data=0`, `resp_id=0`, `resp_err=0`, `last=1`, state IDLE. `req0_ready=req1_ready=0` while `rst=1`.
- Latency: a request accepted on edge N gives `resp_valid=1` with data after edge N.
- Throughput: one request per cycle while `resp_ready` is held high.
- Critical path: request mux → bit reverse → 5-stage mux shifter → reverse → OR → response register.
- `resp_valid` low with `resp_ready` high has no effect.

## Configuration
- `SHIFT_UNIT_ARB_SRA_EN`:
  - Defined: op 10 performs an arithmetic right shift using the fill path.
  - Undefined: the fill logic and second shifter are not built; op 10 is treated as reserved (`resp_data = data`, `resp_err = 1`).

## Test plan
- Reset, then req0 SLL: data 0x0000_0001, amt 31, resp_ready=1 → one cycle later resp_data 0x8000_0000, resp_id 0, resp_err 0.
- Both requesters valid for 4 cycles with resp_ready=1 → grants 0,1,0,1; responses in the same order with matching IDs.
- req1 SRA: data 0xF000_0000, amt 4 → 0xFF00_0000 with the macro defined. Without the macro → 0xF000_0000 with resp_err=1.
- req0 SRL: data 0x8000_0000, amt 0 then amt 31 → 0x8000_0000, then 0x0000_0001.
- resp_ready held 0 for 3 cycles with req1 valid → req1_ready stays 0 and resp_data stable. Raising resp_ready accepts req1 in the same cycle.
- Assert rst while in RESP → the next cycle shows resp_valid 0, and the next grant goes to req0.

Source files
------------

// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing a 32-bit left barrel shifter between two requesters.
// Optional `SHIFT_UNIT_ARB_SRA_EN` builds the arithmetic-right-shift fill path.

module shift_left_32bit (
  input  logic [31:0] data_i,
  input  logic [31:0] shift_sel_i,
  output logic [31:0] result_o
);

  logic [31:0] stage_s [0:5];

  assign stage_s[0] = data_i;

  // Five binary-weighted mux stages; stage i shifts by 2**i.
  for (genvar i = 0; i < 5; i++) begin : g_stage
    assign stage_s[i+1] = shift_sel_i[i]
                          ? {stage_s[i][31-(2**i):0], {(2**i){1'b0}}}
                          : stage_s[i];
  end

  assign result_o = (|shift_sel_i[31:5]) ? 32'd0 : stage_s[5];

endmodule

module shift_unit_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic [4:0]  req0_amt,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req1_amt,
  input  logic [1:0]  req1_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_id,
  output logic        resp_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_id_q, resp_id_d;
  logic        resp_err_q, resp_err_d;

  logic        grant_s;
  logic        any_valid_s;
  logic        can_accept_s;
  logic        accept_s;

  logic [31:0] sel_data_s;
  logic [4:0]  sel_amt_s;
  logic [1:0]  sel_op_s;
  logic [31:0] shift_sel_s;
  logic [31:0] sh_in_s;
  logic [31:0] sh_out_s;
  logic [31:0] srl_s;
  logic [31:0] result_s;
  logic        err_s;

  // Round-robin choice: contention goes to the requester not granted last.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_q;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign any_valid_s  = req0_valid | req1_valid;
  assign can_accept_s = (state_q == IDLE) | ((state_q == RESP) & resp_ready);
  assign accept_s     = can_accept_s & any_valid_s & ~rst;
  assign req0_ready   = accept_s & ~grant_s;
  assign req1_ready   = accept_s &  grant_s;

  assign sel_data_s  = grant_s ? req1_data : req0_data;
  assign sel_amt_s   = grant_s ? req1_amt  : req0_amt;
  assign sel_op_s    = grant_s ? req1_op   : req0_op;
  assign shift_sel_s = {27'd0, sel_amt_s};

  // Right shifts reuse the left shifter on bit-reversed operands.
  assign sh_in_s = (sel_op_s == OP_SLL) ? sel_data_s : rev32(sel_data_s);

  shift_left_32bit u_shift (
    .data_i      (sh_in_s),
    .shift_sel_i (shift_sel_s),
    .result_o    (sh_out_s)
  );

  assign srl_s = rev32(sh_out_s);

`ifdef SHIFT_UNIT_ARB_SRA_EN
  logic [31:0] fill_out_s;
  logic [31:0] fill_s;

  // All-ones is its own bit reversal, so the fill shifter input is a constant.
  shift_left_32bit u_fill (
    .data_i      (32'hFFFF_FFFF),
    .shift_sel_i (shift_sel_s),
    .result_o    (fill_out_s)
  );

  assign fill_s = sel_data_s[31] ? ~rev32(fill_out_s) : 32'd0;

  // Operation select with arithmetic right shift available.
  always_comb begin
    result_s = sel_data_s;
    err_s    = 1'b0;
    case (sel_op_s)
      OP_SLL: begin
        result_s = sh_out_s;
        err_s    = 1'b0;
      end
      OP_SRL: begin
        result_s = srl_s;
        err_s    = 1'b0;
      end
      OP_SRA: begin
        result_s = srl_s | fill_s;
        err_s    = 1'b0;
      end
      default: begin
        result_s = sel_data_s;
        err_s    = 1'b1;
      end
    endcase
  end
`else
  // Operation select; op 10 is reserved in this build.
  always_comb begin
    result_s = sel_data_s;
    err_s    = 1'b0;
    case (sel_op_s)
      OP_SLL: begin
        result_s = sh_out_s;
        err_s    = 1'b0;
      end
      OP_SRL: begin
        result_s = srl_s;
        err_s    = 1'b0;
      end
      default: begin
        result_s = sel_data_s;
        err_s    = 1'b1;
      end
    endcase
  end
`endif

  // Next-state and response-register load decisions.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d      = RESP;
          last_d       = grant_s;
          resp_valid_d = 1'b1;
          resp_data_d  = result_s;
          resp_id_d    = grant_s;
          resp_err_d   = err_s;
        end else begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (accept_s) begin
          state_d      = RESP;
          last_d       = grant_s;
          resp_valid_d = 1'b1;
          resp_data_d  = result_s;
          resp_id_d    = grant_s;
          resp_err_d   = err_s;
        end else if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // State and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_id_q    <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Scoreboard bench for shift_unit_arbiter: directed plan cases plus random traffic
// against a transaction-level model of the arbiter and shift operations.

module tb_shift_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic [4:0]  req0_amt, req1_amt;
  logic [1:0]  req0_op, req1_op;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_id, resp_err;

  always #5 clk = ~clk;

  shift_unit_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_op    (req1_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_err   (resp_err)
  );

  typedef struct packed {
    logic        id;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_busy = 1'b0;
  bit   m_last = 1'b1;
  bit   exp_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_op(input logic id, input logic [31:0] d,
                                  input logic [4:0] a, input logic [1:0] op);
    exp_t e;
    logic signed [31:0] sd;
    sd     = d;
    e.id   = id;
    e.err  = 1'b0;
    e.data = d;
    case (op)
      2'b00: e.data = d << a;
      2'b01: e.data = d >> a;
`ifdef SHIFT_UNIT_ARB_SRA_EN
      2'b10: e.data = sd >>> a;
`endif
      default: begin
        e.data = d;
        e.err  = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Inputs are already driven; checks readiness, predicts, and advances the model.
  task automatic step();
    bit can_acc, acc, g;
    #1;
    can_acc = !rst && (!m_busy || resp_ready);
    if (req0_valid && req1_valid) g = ~m_last;
    else g = req1_valid;
    acc = can_acc && (req0_valid || req1_valid);
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, acc && !g});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, acc && g});
    if (acc) begin
      if (g) q.push_back(ref_op(1'b1, req1_data, req1_amt, req1_op));
      else   q.push_back(ref_op(1'b0, req0_data, req0_amt, req0_op));
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      q.delete();
    end else if (acc) begin
      m_busy = 1'b1;
      m_last = g;
    end else if (resp_ready) begin
      m_busy = 1'b0;
    end
    exp_valid = m_busy;
  endtask

  task automatic drive(input logic r, input logic rr,
                       input logic v0, input logic [31:0] d0, input logic [4:0] a0, input logic [1:0] o0,
                       input logic v1, input logic [31:0] d1, input logic [4:0] a1, input logic [1:0] o1);
    @(negedge clk);
    rst = r; resp_ready = rr;
    req0_valid = v0; req0_data = d0; req0_amt = a0; req0_op = o0;
    req1_valid = v1; req1_data = d1; req1_amt = a1; req1_op = o1;
    step();
  endtask

  // Monitor: compares the presented response against the scoreboard head.
  always @(negedge clk) begin
    #2;
    chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_valid});
    if (resp_valid && exp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: response with no expected entry at %0t", $time);
      end else begin
        chk("resp_data", resp_data, q[0].data);
        chk("resp_id", {31'd0, resp_id}, {31'd0, q[0].id});
        chk("resp_err", {31'd0, resp_err}, {31'd0, q[0].err});
        if (resp_ready && !rst) void'(q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; resp_ready = 1'b0;
    req0_valid = 1'b0; req0_data = 32'd0; req0_amt = 5'd0; req0_op = 2'd0;
    req1_valid = 1'b0; req1_data = 32'd0; req1_amt = 5'd0; req1_op = 2'd0;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 5'd0, 2'd0, 1'b0, 32'd0, 5'd0, 2'd0);
    drive(1'b1, 1'b1, 1'b1, 32'd5, 5'd1, 2'd0, 1'b1, 32'd7, 5'd1, 2'd0);
    #1;
    chk("reset resp_data", resp_data, 32'd0);
    chk("reset resp_id", {31'd0, resp_id}, 32'd0);
    chk("reset resp_err", {31'd0, resp_err}, 32'd0);

    // SLL 1 by 31
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0001, 5'd31, 2'b00, 1'b0, 32'd0, 5'd0, 2'd0);
    // req1 SRA of 0xF000_0000 by 4
    drive(1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 2'd0, 1'b1, 32'hF000_0000, 5'd4, 2'b10);
    // Both valid for four cycles: grants alternate starting with req0
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, 32'h1234_5678 + i, 5'(i), 2'b00,
            1'b1, 32'h8765_4321 + i, 5'(i + 3), 2'b01);
    end
    // SRL by 0 and by 31
    drive(1'b0, 1'b1, 1'b1, 32'h8000_0000, 5'd0, 2'b01, 1'b0, 32'd0, 5'd0, 2'd0);
    drive(1'b0, 1'b1, 1'b1, 32'h8000_0000, 5'd31, 2'b01, 1'b0, 32'd0, 5'd0, 2'd0);
    drive(1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 2'd0, 1'b0, 32'd0, 5'd0, 2'd0);
    // Back-pressure: pending response held while req1 waits
    drive(1'b0, 1'b0, 1'b1, 32'hA5A5_0F0F, 5'd7, 2'b11, 1'b0, 32'd0, 5'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 2'd0, 1'b1, 32'h0F0F_1234, 5'd8, 2'b00);
    end
    drive(1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 2'd0, 1'b1, 32'h0F0F_1234, 5'd8, 2'b00);
    // Reset while a response is pending, then contention goes to req0
    drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 5'd3, 2'b10, 1'b0, 32'd0, 5'd0, 2'd0);
    drive(1'b1, 1'b0, 1'b1, 32'h1111_1111, 5'd1, 2'b00, 1'b1, 32'h2222_2222, 5'd2, 2'b00);
    drive(1'b0, 1'b1, 1'b1, 32'h3333_3333, 5'd4, 2'b01, 1'b1, 32'h4444_4444, 5'd5, 2'b10);

    for (int i = 0; i < 3000; i++) begin
      logic r;
      r = ($urandom_range(0, 99) == 0);
      drive(r, r ? 1'b0 : ($urandom_range(0, 9) < 7),
            $urandom_range(0, 1), $urandom, 5'($urandom), 2'($urandom),
            $urandom_range(0, 1), $urandom, 5'($urandom), 2'($urandom));
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 2'd0, 1'b0, 32'd0, 5'd0, 2'd0);
    end
    @(negedge clk);
    #3;
    chk("scoreboard drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
